// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - request, ALU drive and response bundle for alu_sequencer
interface alu_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_a;
  logic [3:0] req_b;
  logic [2:0] req_opcode;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_opcode;
  logic [3:0] alu_c;
  logic       alu_carr;
  logic       alu_sign;
  logic       alu_zero;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_c;
  logic       rsp_carr;
  logic       rsp_sign;
  logic       rsp_zero;
  logic       rsp_err;
  logic [7:0] txn_count;

  modport slave (
    input  req_valid, req_a, req_b, req_opcode,
    input  alu_c, alu_carr, alu_sign, alu_zero,
    input  rsp_ready,
    output req_ready, alu_a, alu_b, alu_opcode,
    output rsp_valid, rsp_c, rsp_carr, rsp_sign, rsp_zero, rsp_err, txn_count
  );

  modport master (
    output req_valid, req_a, req_b, req_opcode,
    output alu_c, alu_carr, alu_sign, alu_zero,
    output rsp_ready,
    input  req_ready, alu_a, alu_b, alu_opcode,
    input  rsp_valid, rsp_c, rsp_carr, rsp_sign, rsp_zero, rsp_err, txn_count
  );
endinterface

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - holds one request on a bit-serial ALU for HOLD_CYCLES clocks and returns the result
module alu_sequencer #(
  parameter int unsigned HOLD_CYCLES = 8
) (
  input logic            clk,
  input logic            rst,
  alu_sequencer_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_RESP} state_t;

  localparam logic [2:0] OP_NOP    = 3'b111;
  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

  state_t     state_q;
  logic [3:0] cnt_q;
  logic       req_ready_q;
  logic [3:0] alu_a_q;
  logic [3:0] alu_b_q;
  logic [2:0] alu_opcode_q;
  logic       rsp_valid_q;
  logic [3:0] rsp_c_q;
  logic       rsp_carr_q;
  logic       rsp_sign_q;
  logic       rsp_zero_q;
  logic       rsp_err_q;
  logic [7:0] txn_q;

  logic accept;
  logic legal;

  assign accept = (state_q == S_IDLE) && bus.req_valid && req_ready_q;
  assign legal  = (bus.req_opcode <= 3'd4);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      req_ready_q  <= 1'b0;
      alu_a_q      <= 4'd0;
      alu_b_q      <= 4'd0;
      alu_opcode_q <= OP_NOP;
      rsp_valid_q  <= 1'b0;
      rsp_c_q      <= 4'd0;
      rsp_carr_q   <= 1'b0;
      rsp_sign_q   <= 1'b0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      txn_q        <= 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            req_ready_q <= 1'b0;
            if (legal) begin
              alu_a_q      <= bus.req_a;
              alu_b_q      <= bus.req_b;
              alu_opcode_q <= bus.req_opcode;
              cnt_q        <= HOLD_LOAD;
              state_q      <= S_ISSUE;
            end else begin
              // Illegal opcodes never reach the ALU; answer immediately with an error.
              rsp_c_q     <= 4'd0;
              rsp_carr_q  <= 1'b0;
              rsp_sign_q  <= 1'b0;
              rsp_zero_q  <= 1'b0;
              rsp_err_q   <= 1'b1;
              rsp_valid_q <= 1'b1;
              state_q     <= S_RESP;
            end
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_CAPTURE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_CAPTURE: begin
          rsp_c_q      <= bus.alu_c;
          rsp_carr_q   <= bus.alu_carr;
          rsp_sign_q   <= bus.alu_sign;
          rsp_zero_q   <= bus.alu_zero;
          rsp_err_q    <= 1'b0;
          alu_opcode_q <= OP_NOP;
          rsp_valid_q  <= 1'b1;
          state_q      <= S_RESP;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            txn_q       <= txn_q + 8'd1;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_opcode = alu_opcode_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_c      = rsp_c_q;
  assign bus.rsp_carr   = rsp_carr_q;
  assign bus.rsp_sign   = rsp_sign_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.txn_count  = txn_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed scoreboard bench for alu_sequencer with a behavioural ALU
module tb_alu_sequencer;

  localparam int HOLD = 8;

  typedef struct packed {
    logic       err;
    logic       carr;
    logic       sign;
    logic       zero;
    logic [3:0] c;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_txn = 8'd0;
  rsp_t       sb[$];
  int         cyc = 0;
  int         last_acc = -1;
  int         hs = 0;
  bit         spacing_en = 1'b0;

  alu_sequencer_if bus ();

  alu_sequencer #(.HOLD_CYCLES(HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: {carr, sign, zero, c}; SUB computes B-A with carr as borrow.
  function automatic logic [6:0] alu_calc(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] w;
    w = 5'd0;
    case (op)
      3'b001:  w = {1'b0, ~(a ^ b)};
      3'b010:  w = {1'b0, b} - {1'b0, a};
      3'b011:  w = {1'b0, ~(a & b)};
      3'b100:  w = {1'b0, a} + {1'b0, b};
      default: w = 5'd0;
    endcase
    return {w[4], w[3], (w[3:0] == 4'd0), w[3:0]};
  endfunction

  function automatic rsp_t model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    rsp_t r;
    if (op > 3'd4) r = 8'b1000_0000;
    else           r = {1'b0, alu_calc(op, a, b)};
    return r;
  endfunction

  assign {bus.alu_carr, bus.alu_sign, bus.alu_zero, bus.alu_c} =
         alu_calc(bus.alu_opcode, bus.alu_a, bus.alu_b);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic rsp_t dut_rsp();
    return {bus.rsp_err, bus.rsp_carr, bus.rsp_sign, bus.rsp_zero, bus.rsp_c};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic pop_cmp(input string tag);
    rsp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_underflow"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk(tag, 32'(dut_rsp()), 32'(e));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    exp_txn = 8'd0;
    tick();
  endtask

  // One request through the full handshake; accepting edge counts as edge 1.
  task automatic run_op(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                        input int stall, input int exp_lat);
    rsp_t g;
    int   n;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_opcode = op;
    bus.req_a      = a;
    bus.req_b      = b;
    sb.push_back(model(op, a, b));
    tick();
    bus.req_valid  = 1'b0;
    bus.req_opcode = 3'($urandom);
    bus.req_a      = 4'($urandom);
    bus.req_b      = 4'($urandom);
    n = 1;
    while (bus.rsp_valid !== 1'b1 && n < 40) begin
      chk("issue_hold", 32'({bus.alu_opcode, bus.alu_a, bus.alu_b}), 32'({op, a, b}));
      tick();
      n++;
    end
    chk("latency", 32'(n), 32'(exp_lat));
    chk("alu_op_nop_in_resp", 32'(bus.alu_opcode), 32'd7);
    chk("req_ready_in_resp", 32'(bus.req_ready), 32'd0);
    g = dut_rsp();
    pop_cmp("rsp");
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("stall_stable", 32'({bus.rsp_valid, dut_rsp()}), 32'({1'b1, g}));
      chk("stall_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    exp_txn = exp_txn + 8'd1;
    bus.rsp_ready = 1'b0;
    chk("rsp_valid_drop", 32'(bus.rsp_valid), 32'd0);
    chk("txn_count", 32'(bus.txn_count), 32'(exp_txn));
    chk("req_ready_back", 32'(bus.req_ready), 32'd1);
    chk("alu_op_idle", 32'(bus.alu_opcode), 32'd7);
  endtask

  // One clock of free-running traffic: push on accept, pop on response handshake.
  task automatic pipe_step();
    if (bus.req_valid && bus.req_ready) begin
      sb.push_back(model(bus.req_opcode, bus.req_a, bus.req_b));
      if (spacing_en && last_acc >= 0) chk("b2b_spacing", 32'(cyc - last_acc), 32'(HOLD + 3));
      last_acc = cyc;
    end
    if (bus.rsp_valid && bus.rsp_ready) begin
      pop_cmp("pipe_rsp");
      exp_txn = exp_txn + 8'd1;
      hs++;
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int guard;
    bus.req_valid  = 1'b0;
    bus.req_opcode = 3'd0;
    bus.req_a      = 4'd0;
    bus.req_b      = 4'd0;
    bus.rsp_ready  = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    tick();
    chk("rst_alu_opcode", 32'(bus.alu_opcode), 32'd7);
    chk("rst_alu_ab", 32'({bus.alu_a, bus.alu_b}), 32'd0);
    chk("rst_rsp", 32'({bus.rsp_valid, dut_rsp()}), 32'd0);
    chk("rst_txn", 32'(bus.txn_count), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    rst = 1'b0;
    tick();
    chk("req_ready_after_rst", 32'(bus.req_ready), 32'd1);

    run_op(3'b100, 4'b0011, 4'b0101, 0, HOLD + 2);
    do_reset();
    run_op(3'b001, 4'b1010, 4'b1100, 0, HOLD + 2);
    run_op(3'b011, 4'b1111, 4'b0110, 0, HOLD + 2);
    run_op(3'b010, 4'b0010, 4'b0111, 0, HOLD + 2);
    chk("txn_after_three", 32'(bus.txn_count), 32'd3);
    run_op(3'b010, 4'b0111, 4'b0010, 0, HOLD + 2);
    run_op(3'b000, 4'b1001, 4'b0110, 0, HOLD + 2);
    run_op(3'b101, 4'b1111, 4'b1111, 0, 1);
    run_op(3'b111, 4'b0001, 4'b0001, 0, 1);
    run_op(3'b100, 4'b1111, 4'b0001, 5, HOLD + 2);

    // Reset during the fourth ISSUE cycle.
    bus.req_valid  = 1'b1;
    bus.req_opcode = 3'b100;
    bus.req_a      = 4'b0110;
    bus.req_b      = 4'b0001;
    tick();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("mid_issue_op", 32'(bus.alu_opcode), 32'd4);
    rst = 1'b1;
    tick();
    chk("mid_rst_alu_opcode", 32'(bus.alu_opcode), 32'd7);
    chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mid_rst_txn", 32'(bus.txn_count), 32'd0);
    chk("mid_rst_req_ready", 32'(bus.req_ready), 32'd0);
    rst = 1'b0;
    exp_txn = 8'd0;
    tick();
    chk("mid_rst_release_ready", 32'(bus.req_ready), 32'd1);
    for (int i = 0; i < HOLD + 3; i++) begin
      chk("mid_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
      tick();
    end

    // Back-to-back with req_valid held high.
    bus.req_valid  = 1'b1;
    bus.req_opcode = 3'b100;
    bus.req_a      = 4'b0001;
    bus.req_b      = 4'b0010;
    bus.rsp_ready  = 1'b1;
    spacing_en     = 1'b1;
    last_acc       = -1;
    for (int i = 0; i < 4 * (HOLD + 3) + 1; i++) pipe_step();
    bus.req_valid = 1'b0;
    spacing_en    = 1'b0;
    guard = 0;
    while (sb.size() > 0 && guard < 40) begin
      pipe_step();
      guard++;
    end
    chk("b2b_drained", 32'(sb.size()), 32'd0);
    chk("b2b_txn", 32'(bus.txn_count), 32'(exp_txn));

    // Counter wrap: 255 responses, then one more.
    do_reset();
    hs = 0;
    bus.req_valid  = 1'b1;
    bus.req_opcode = 3'b110;
    bus.rsp_ready  = 1'b1;
    guard = 0;
    while (hs < 255 && guard < 2000) begin
      pipe_step();
      guard++;
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    chk("wrap_hs", 32'(hs), 32'd255);
    chk("txn_255", 32'(bus.txn_count), 32'd255);
    run_op(3'b101, 4'b0000, 4'b0000, 0, 1);
    chk("txn_wrap_zero", 32'(bus.txn_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
